// File: rtl/elevator_request_scheduler.sv
// Collective-sweep elevator request scheduler: keeps a map of pending floor calls
// and steers the downstream controller to the nearest pending floor in the sweep direction.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 51,
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_valid,
  input  logic [6:0] call_floor,
  input  logic [6:0] cur_floor,
  input  logic       stop,
  output logic [6:0] req_floor,
  output logic       dir_up,
  output logic       busy,
  output logic       door_hold,
  output logic [5:0] pending_count,
  output logic       call_err
);

  localparam int              CNT_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [6:0]       FLOOR_LIMIT = 7'(NUM_FLOORS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    DWELL = 2'd3
  } state_t;

  function automatic logic [5:0] popcount(input logic [NUM_FLOORS-1:0] map);
    logic [5:0] n;
    n = 6'd0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      n = n + 6'(map[f]);
    end
    return n;
  endfunction

  state_t                  state_r, state_s;
  logic [NUM_FLOORS-1:0]   pending_r, pending_s;
  logic                    dir_up_r, dir_up_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [6:0]              req_floor_r, req_floor_s;
  logic [5:0]              count_r;
  logic                    call_err_r;

  logic       cur_valid_s, call_ok_s, arrival_s, clear_s;
  logic       above_s, below_s, at_cur_s;
  logic [6:0] up_target_s, down_target_s;

  assign cur_valid_s = (cur_floor < FLOOR_LIMIT);
  assign call_ok_s   = call_valid && (call_floor < FLOOR_LIMIT);
  assign arrival_s   = ((state_r == UP) || (state_r == DOWN)) && stop && (cur_floor == req_floor_r);

  // Scan the pending map for the nearest call above/below the car and a call at the car.
  always_comb begin
    above_s       = 1'b0;
    below_s       = 1'b0;
    at_cur_s      = 1'b0;
    up_target_s   = 7'd0;
    down_target_s = 7'd0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      up_target_s   = (pending_r[f] && (7'(f) > cur_floor) && !above_s) ? 7'(f) : up_target_s;
      down_target_s = (pending_r[f] && (7'(f) < cur_floor)) ? 7'(f) : down_target_s;
      above_s       = above_s | (pending_r[f] && (7'(f) > cur_floor));
      below_s       = below_s | (pending_r[f] && (7'(f) < cur_floor));
      at_cur_s      = at_cur_s | (pending_r[f] && (7'(f) == cur_floor));
    end
  end

  // Sweep FSM: next state, direction, dwell counter and service-clear request.
  always_comb begin
    state_s  = state_r;
    dir_up_s = dir_up_r;
    cnt_s    = cnt_r;
    clear_s  = 1'b0;
    if (!cur_valid_s) begin
      state_s = IDLE;
      cnt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (at_cur_s) begin
            state_s = DWELL;
            cnt_s   = DWELL_LOAD;
            clear_s = 1'b1;
          end else if (above_s) begin
            state_s  = UP;
            dir_up_s = 1'b1;
          end else if (below_s) begin
            state_s  = DOWN;
            dir_up_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        UP, DOWN: begin
          // A call at the car keeps the sweep alive until the controller reports the stop.
          if (arrival_s) begin
            state_s = DWELL;
            cnt_s   = DWELL_LOAD;
            clear_s = 1'b1;
          end else if ((state_r == UP) ? (above_s || at_cur_s) : (below_s || at_cur_s)) begin
            state_s = state_r;
          end else begin
            state_s = IDLE;
          end
        end
        DWELL: begin
          if (call_ok_s && (call_floor == cur_floor)) begin
            cnt_s = DWELL_LOAD;
          end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_s = cnt_r - CNT_W'(1);
          end else if (dir_up_r ? above_s : below_s) begin
            state_s = dir_up_r ? UP : DOWN;
          end else if (dir_up_r ? below_s : above_s) begin
            state_s  = dir_up_r ? DOWN : UP;
            dir_up_s = ~dir_up_r;
          end else begin
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Pending map update; the service clear is applied after the call set so it wins.
  always_comb begin
    pending_s = pending_r;
    if (cur_valid_s) begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        pending_s[f] = (pending_r[f]
                        | (call_ok_s && (call_floor == 7'(f))
                           && !((state_r == DWELL) && (cur_floor == 7'(f)))))
                       & ~(clear_s && (cur_floor == 7'(f)));
      end
    end else begin
      pending_s = pending_r;
    end
  end

  // Target floor follows the next state so a new call reaches req_floor one edge after it lands.
  always_comb begin
    req_floor_s = req_floor_r;
    case (state_s)
      UP:          req_floor_s = above_s ? up_target_s : req_floor_r;
      DOWN:        req_floor_s = below_s ? down_target_s : req_floor_r;
      IDLE, DWELL: req_floor_s = cur_valid_s ? cur_floor : req_floor_r;
      default:     req_floor_s = req_floor_r;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pending_r   <= {NUM_FLOORS{1'b0}};
      dir_up_r    <= 1'b1;
      cnt_r       <= {CNT_W{1'b0}};
      req_floor_r <= 7'd0;
      count_r     <= 6'd0;
      call_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      dir_up_r    <= dir_up_s;
      cnt_r       <= cnt_s;
      req_floor_r <= req_floor_s;
      count_r     <= popcount(pending_s);
      call_err_r  <= call_valid && !(call_floor < FLOOR_LIMIT);
    end
  end

  assign req_floor     = req_floor_r;
  assign dir_up        = dir_up_r;
  assign busy          = (state_r != IDLE);
  assign door_hold     = (state_r == DWELL);
  assign pending_count = count_r;
  assign call_err      = call_err_r;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: expected outputs are queued as
// stimulus is driven and compared after the following clock edge.
module tb_elevator_request_scheduler;

  logic       clk;
  logic       reset;
  logic       call_valid;
  logic [6:0] call_floor;
  logic [6:0] cur_floor;
  logic       stop;
  logic [6:0] req_floor;
  logic       dir_up;
  logic       busy;
  logic       door_hold;
  logic [5:0] pending_count;
  logic       call_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    req;
    int    dir;
    int    busy;
    int    door;
    int    cnt;
    int    err;
  } exp_t;

  exp_t sb_q[$];

  elevator_request_scheduler #(.NUM_FLOORS(51), .DWELL_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_valid    (call_valid),
    .call_floor    (call_floor),
    .cur_floor     (cur_floor),
    .stop          (stop),
    .req_floor     (req_floor),
    .dir_up        (dir_up),
    .busy          (busy),
    .door_hold     (door_hold),
    .pending_count (pending_count),
    .call_err      (call_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int req, input int dir, input int bsy,
                          input int door, input int cnt, input int err);
    exp_t e;
    e.tag = tag; e.req = req; e.dir = dir; e.busy = bsy;
    e.door = door; e.cnt = cnt; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, ".req_floor"},     int'(req_floor),     e.req);
      check_val({e.tag, ".dir_up"},        int'(dir_up),        e.dir);
      check_val({e.tag, ".busy"},          int'(busy),          e.busy);
      check_val({e.tag, ".door_hold"},     int'(door_hold),     e.door);
      check_val({e.tag, ".pending_count"}, int'(pending_count), e.cnt);
      check_val({e.tag, ".call_err"},      int'(call_err),      e.err);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int req, input int dir, input int bsy,
                      input int door, input int cnt, input int err);
    push_exp(tag, req, dir, bsy, door, cnt, err);
    tick();
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; call_valid = 1'b0; call_floor = 7'd0; cur_floor = 7'd0; stop = 1'b0;
    step("rst", 0, 1, 0, 0, 0, 0);
    reset = 1'b1;

    // Single call from floor 0 to floor 5, then dwell and return to idle
    call_valid = 1'b1; call_floor = 7'd5;
    step("c5_e1", 0, 1, 0, 0, 1, 0);
    call_valid = 1'b0;
    step("c5_e2", 5, 1, 1, 0, 1, 0);
    cur_floor = 7'd5; stop = 1'b1;
    step("arr5", 5, 1, 1, 1, 0, 0);
    stop = 1'b0;
    repeat (3) step("dw5", 5, 1, 1, 1, 0, 0);
    step("idle5", 5, 1, 0, 0, 0, 0);

    // Mid-travel retarget to a nearer floor ahead
    cur_floor = 7'd10;
    step("cur10", 10, 1, 0, 0, 0, 0);
    call_valid = 1'b1; call_floor = 7'd20;
    step("c20_e1", 10, 1, 0, 0, 1, 0);
    call_valid = 1'b0;
    step("c20_e2", 20, 1, 1, 0, 1, 0);
    cur_floor = 7'd12; call_valid = 1'b1; call_floor = 7'd15;
    step("c15_e1", 20, 1, 1, 0, 2, 0);
    call_valid = 1'b0;
    step("c15_e2", 15, 1, 1, 0, 2, 0);
    cur_floor = 7'd15; stop = 1'b1;
    step("arr15", 15, 1, 1, 1, 1, 0);
    stop = 1'b0;
    repeat (3) step("dw15", 15, 1, 1, 1, 1, 0);
    step("go20", 20, 1, 1, 0, 1, 0);

    // Calls ahead and behind: finish the up sweep, then reverse
    call_valid = 1'b1; call_floor = 7'd30;
    step("c30", 20, 1, 1, 0, 2, 0);
    call_floor = 7'd5;
    step("c5b", 20, 1, 1, 0, 3, 0);
    call_valid = 1'b0; cur_floor = 7'd20; stop = 1'b1;
    step("arr20", 20, 1, 1, 1, 2, 0);
    stop = 1'b0;
    repeat (3) step("dw20", 20, 1, 1, 1, 2, 0);
    step("go30", 30, 1, 1, 0, 2, 0);
    cur_floor = 7'd30; stop = 1'b1;
    step("arr30", 30, 1, 1, 1, 1, 0);
    stop = 1'b0;
    repeat (3) step("dw30", 30, 1, 1, 1, 1, 0);
    step("rev5", 5, 0, 1, 0, 1, 0);
    cur_floor = 7'd5; stop = 1'b1;
    step("arr5b", 5, 0, 1, 1, 0, 0);
    stop = 1'b0;
    repeat (3) step("dw5b", 5, 0, 1, 1, 0, 0);
    step("idle5b", 5, 0, 0, 0, 0, 0);

    // Call at the car while dwelling reloads the door timer
    cur_floor = 7'd8; call_valid = 1'b1; call_floor = 7'd8;
    step("c8", 8, 0, 0, 0, 1, 0);
    call_valid = 1'b0;
    step("dw8_3", 8, 0, 1, 1, 0, 0);
    step("dw8_2", 8, 0, 1, 1, 0, 0);
    step("dw8_1", 8, 0, 1, 1, 0, 0);
    call_valid = 1'b1; call_floor = 7'd8;
    step("reload8", 8, 0, 1, 1, 0, 0);
    call_valid = 1'b0;
    repeat (3) step("dw8_rl", 8, 0, 1, 1, 0, 0);
    step("end8", 8, 0, 0, 0, 0, 0);

    // Out-of-range calls are rejected with a single-cycle error pulse
    call_valid = 1'b1; call_floor = 7'd51;
    step("err51", 8, 0, 0, 0, 0, 1);
    call_valid = 1'b0;
    step("err51_off", 8, 0, 0, 0, 0, 0);
    call_valid = 1'b1; call_floor = 7'd127;
    step("err127", 8, 0, 0, 0, 0, 1);
    call_valid = 1'b0;
    step("err127_off", 8, 0, 0, 0, 0, 0);

    // Travel to 40, invalid floor report forces idle, then asynchronous reset mid-travel
    call_valid = 1'b1; call_floor = 7'd40;
    step("c40", 8, 0, 0, 0, 1, 0);
    call_valid = 1'b0;
    step("go40", 40, 1, 1, 0, 1, 0);
    cur_floor = 7'd60;
    step("badcur", 40, 1, 0, 0, 1, 0);
    cur_floor = 7'd20;
    step("resume40", 40, 1, 1, 0, 1, 0);
    #3;
    reset = 1'b0;
    push_exp("arst", 0, 1, 0, 0, 0, 0);
    #1;
    compare_out();
    step("arst_hold", 0, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, 51, number of serviced floors (0..NUM_FLOORS-1) SHALL apply.
REQ-002 Parameter DWELL_CYCLES, 4, door-hold cycles at each serviced floor SHALL apply.
REQ-003 One clock; reset is asynchronous and active-low. Ports `clk` and `reset` SHALL follow this.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 call_valid  input  1  a floor call is presented this cycle.
REQ-007 call_floor  input  7  requested floor, sampled when call_valid=1.
REQ-008 cur_floor  input  7  current floor from the downstream elevator controller.
REQ-009 stop  input  1  elevator stationary with door open, from the downstream controller.
REQ-010 req_floor  output  7  target floor, drives the downstream controller's floor request.
REQ-011 dir_up  output  1  current sweep direction (1=up).
REQ-012 busy  output  1  state is not IDLE.
REQ-013 door_hold  output  1  state is DWELL.
REQ-014 pending_count  output  6  number of set bits in the pending map.
REQ-015 call_err  output  1  one-cycle pulse on a rejected call.

Function
REQ-016 The block SHALL hold a NUM_FLOORS-bit pending map: bit F set means floor F awaits service.
REQ-017 A call with call_floor < NUM_FLOORS SHALL set its bit at the next edge; setting an already-set bit has no effect.
REQ-018 A call with call_floor >= NUM_FLOORS SHALL be discarded, and call_err SHALL be 1 for exactly the following cycle.
REQ-019 FSM states SHALL be IDLE, UP, DOWN and DWELL.
REQ-020 IDLE with bit[cur_floor] set SHALL go to DWELL.
REQ-021 IDLE otherwise SHALL go to UP if any bit is above cur_floor, else to DOWN if any bit is below, else stay in IDLE.
REQ-022 UP target: the lowest set bit strictly above cur_floor.
REQ-023 DOWN target: the highest set bit strictly below cur_floor.
REQ-024 The target SHALL be re-evaluated every cycle, so a nearer call ahead of the car retargets mid-travel.
REQ-025 Arrival is defined as UP/DOWN with stop=1 and cur_floor==req_floor.
REQ-026 On arrival: clear bit[cur_floor], load the dwell counter with DWELL_CYCLES-1, go to DWELL.
REQ-027 DWELL SHALL decrement the counter each cycle.
REQ-028 At a counter value of 0, DWELL SHALL leave as follows: continue the dir_up direction if bits exist ahead, else reverse and toggle dir_up if bits exist behind, else go to IDLE.
REQ-029 A call to cur_floor during DWELL SHALL NOT set its bit and SHALL reload the counter to DWELL_CYCLES-1.
REQ-030 A same-cycle call and arrival clear on the same floor SHALL leave that bit clear.
REQ-031 req_floor SHALL be registered.
REQ-032 In UP/DOWN, req_floor SHALL equal the target one edge after the pending/state change.
REQ-033 In IDLE and DWELL, req_floor SHALL equal cur_floor.
REQ-034 Call-to-req_floor latency SHALL be 2 edges: pending set at edge N, req_floor updated at edge N+1.
REQ-035 pending_count SHALL be registered and consistent with the pending map after each edge.
REQ-036 A cur_floor >= NUM_FLOORS SHALL force IDLE with req_floor held, and SHALL NOT change the pending map.

Reset
REQ-037 While reset=0: pending map 0, state IDLE, req_floor 0, dir_up 1, busy 0, door_hold 0, pending_count 0, call_err 0, dwell counter 0.
REQ-038 Reset SHALL take effect asynchronously and abandon any travel or dwell; calls are sampled from the first edge after release.

Verification
REQ-039 Reset release, cur_floor=0, call 5 -> req_floor=5 at edge 2, dir_up=1, busy=1; stop=1 with cur_floor=5 -> door_hold=1 for 4 cycles, pending_count=0, then IDLE.
REQ-040 cur_floor=10 moving UP to 20, call 15 mid-travel -> req_floor changes to 15; after 15 is serviced -> req_floor=20.
REQ-041 At cur_floor=20 in UP, pending {30,5} -> service 30 first, then dir_up=0 and req_floor=5.
REQ-042 Call 51, then call 127 -> call_err pulses once each, pending_count stays 0, state unchanged.
REQ-043 DWELL at 8, call 8 at counter=1 -> counter reloads, door_hold lasts 4 more cycles, pending_count unchanged.
REQ-044 reset driven 0 mid-travel to 40 (asynchronously, between clock edges) -> all outputs immediately at reset values, pending_count=0.
